// File: rtl/effect_xfade_ctrl.sv
// Click-free effect insertion: linear, sample-counted crossfade between the dry and wet paths.
// Latency: exactly 1 clock from a dry_valid strobe to audio_out/audio_out_valid.
// Backpressure: none; the block follows the dry_valid strobe and never stalls the upstream path.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   effect_en         requested effect state (1 = wet), sampled only on dry_valid cycles
//   dry_in/dry_valid  bypass-path sample and strobe (the timing reference)
//   wet_in/wet_valid  effect-path sample and strobe (strobe feeds only the alignment check)
//   audio_out/_valid  registered mix and registered copy of dry_valid
//   fade_state        0 BYPASS, 1 FADE_IN, 2 ACTIVE, 3 FADE_OUT
//   busy              high while a fade is in progress
//   align_err         sticky dry/wet strobe mismatch flag
//
// Build option: define EFFECT_XFADE_ALIGN_CHECK_EN to build the dry/wet strobe
// alignment check; without it align_err is constant 0.
//
// FADE_LOG2 is legal in 0..8; 0 gives an instant switch (FULL = 1).

module effect_xfade_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FADE_LOG2  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         effect_en,
    input  logic signed [DATA_WIDTH-1:0] dry_in,
    input  logic                         dry_valid,
    input  logic signed [DATA_WIDTH-1:0] wet_in,
    input  logic                         wet_valid,
    output logic signed [DATA_WIDTH-1:0] audio_out,
    output logic                         audio_out_valid,
    output logic [1:0]                   fade_state,
    output logic                         busy,
    output logic                         align_err
);

    // Gain counter spans 0..FULL inclusive, hence one bit more than FADE_LOG2.
    localparam int GW = FADE_LOG2 + 1;
    // Signed product width: DATA_WIDTH sample times a non-negative gain up to 2^FADE_LOG2.
    localparam int PW = DATA_WIDTH + FADE_LOG2 + 1;
    // The sum of the two products carries one extra bit.
    localparam int SW = PW + 1;

    localparam logic [GW-1:0] FULL_G  = GW'(1 << FADE_LOG2);
    localparam logic [GW-1:0] G_ONE   = GW'(1);
    localparam logic [GW-1:0] G_TOP   = FULL_G - G_ONE;
    localparam bit            FULL_IS_ONE = (FADE_LOG2 == 0);

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        FADE_IN  = 2'd1,
        ACTIVE   = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   g_q;
    logic [GW-1:0]   g_d;

    // ------------------------------------------------------------------
    // Mix datapath: (wet*g + dry*(FULL-g)) >>> FADE_LOG2, using g before
    // this strobe's update.
    // ------------------------------------------------------------------
    logic [GW-1:0]          g_inv;
    logic signed [PW-1:0]   wet_ext;
    logic signed [PW-1:0]   dry_ext;
    logic signed [PW-1:0]   g_ext;
    logic signed [PW-1:0]   g_inv_ext;
    logic signed [PW-1:0]   p_wet;
    logic signed [PW-1:0]   p_dry;
    logic signed [SW-1:0]   mix_sum;
    logic signed [DATA_WIDTH-1:0] mix;
    logic                   unused_mix_bits;

    assign g_inv     = FULL_G - g_q;
    assign wet_ext   = {{(PW-DATA_WIDTH){wet_in[DATA_WIDTH-1]}}, wet_in};
    assign dry_ext   = {{(PW-DATA_WIDTH){dry_in[DATA_WIDTH-1]}}, dry_in};
    // Gains are never negative, so zero-extension keeps them positive as signed operands.
    assign g_ext     = {{(PW-GW){1'b0}}, g_q};
    assign g_inv_ext = {{(PW-GW){1'b0}}, g_inv};
    assign p_wet     = wet_ext * g_ext;
    assign p_dry     = dry_ext * g_inv_ext;
    assign mix_sum   = {p_wet[PW-1], p_wet} + {p_dry[PW-1], p_dry};
    // Arithmetic shift then truncation is the same as slicing from bit FADE_LOG2;
    // the convex mix guarantees the discarded upper bits are pure sign.
    assign mix       = mix_sum[FADE_LOG2 +: DATA_WIDTH];
    assign unused_mix_bits = ^mix_sum;

    // ------------------------------------------------------------------
    // Fade FSM: next state and gain, evaluated only on dry_valid strobes.
    // Reversals step g by one in the opposite direction, so the gain never jumps.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        if (dry_valid) begin
            unique case (state_q)
                BYPASS: begin
                    if (effect_en) begin
                        g_d     = G_ONE;
                        state_d = FULL_IS_ONE ? ACTIVE : FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (effect_en) begin
                        g_d     = g_q + G_ONE;
                        state_d = (g_q == G_TOP) ? ACTIVE : FADE_IN;
                    end else begin
                        g_d     = g_q - G_ONE;
                        state_d = (g_q == G_ONE) ? BYPASS : FADE_OUT;
                    end
                end
                ACTIVE: begin
                    if (!effect_en) begin
                        g_d     = G_TOP;
                        state_d = FULL_IS_ONE ? BYPASS : FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    if (effect_en) begin
                        g_d     = g_q + G_ONE;
                        state_d = (g_q == G_TOP) ? ACTIVE : FADE_IN;
                    end else begin
                        g_d     = g_q - G_ONE;
                        state_d = (g_q == G_ONE) ? BYPASS : FADE_OUT;
                    end
                end
                default: begin
                    g_d     = '0;
                    state_d = BYPASS;
                end
            endcase
        end
    end

    // State, gain and output registers. audio_out only loads on strobes so it
    // holds its last value between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= BYPASS;
            g_q             <= '0;
            audio_out       <= '0;
            audio_out_valid <= 1'b0;
        end else begin
            state_q         <= state_d;
            g_q             <= g_d;
            audio_out_valid <= dry_valid;
            if (dry_valid) begin
                audio_out <= mix;
            end
        end
    end

    assign fade_state = state_q;
    assign busy       = (state_q == FADE_IN) || (state_q == FADE_OUT);

    // ------------------------------------------------------------------
    // Optional dry/wet strobe alignment monitor. Sticky until reset and
    // purely observational: the mix always follows dry_valid.
    // ------------------------------------------------------------------
`ifdef EFFECT_XFADE_ALIGN_CHECK_EN
    logic align_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else if (dry_valid != wet_valid) begin
            align_err_q <= 1'b1;
        end
    end

    assign align_err = align_err_q;
`else
    logic unused_wet_valid;

    assign unused_wet_valid = wet_valid;
    assign align_err        = 1'b0;
`endif

endmodule

// File: tb/tb_effect_xfade_ctrl.sv
// Self-checking bench for effect_xfade_ctrl with FULL = 4, dry = 1000, wet = -1000.
// Latency: each strobe's expected mix is queued and popped when audio_out_valid rises.
// Backpressure: none; stimulus is strobe-paced with idle cycles between samples.

module tb_effect_xfade_ctrl;

    localparam int DW = 32;
    localparam int FL = 2;

`ifdef EFFECT_XFADE_ALIGN_CHECK_EN
    localparam logic ALIGN_ON = 1'b1;
`else
    localparam logic ALIGN_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 effect_en = 1'b0;
    logic signed [DW-1:0] dry_in = 32'sd1000;
    logic                 dry_valid = 1'b0;
    logic signed [DW-1:0] wet_in = -32'sd1000;
    logic                 wet_valid = 1'b0;
    logic signed [DW-1:0] audio_out;
    logic                 audio_out_valid;
    logic [1:0]           fade_state;
    logic                 busy;
    logic                 align_err;

    effect_xfade_ctrl #(.DATA_WIDTH(DW), .FADE_LOG2(FL)) dut (
        .clk             (clk),
        .rst             (rst),
        .effect_en       (effect_en),
        .dry_in          (dry_in),
        .dry_valid       (dry_valid),
        .wet_in          (wet_in),
        .wet_valid       (wet_valid),
        .audio_out       (audio_out),
        .audio_out_valid (audio_out_valid),
        .fade_state      (fade_state),
        .busy            (busy),
        .align_err       (align_err)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_q[$];
    logic exp_align = 1'b0;
    logic rst_seen;
    int   last_out = 0;
    bit   have_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) rst_seen <= rst;

    // Output monitor: reset values, scoreboard pops, hold between strobes,
    // bounded step size, busy/state relation, alignment flag.
    always @(negedge clk) begin
        if (rst_seen) begin
            chk("rst_out", audio_out, 0);
            chk("rst_valid", int'(audio_out_valid), 0);
            chk("rst_state", int'(fade_state), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_align", int'(align_err), 0);
            last_out  = 0;
            have_prev = 1'b0;
        end else begin
            if (audio_out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("mix_out", audio_out, exp_q.pop_front());
                end
                if (have_prev) begin
                    chk("step_le_500",
                        int'((audio_out - last_out <= 500) && (last_out - audio_out <= 500)), 1);
                end
                last_out  = audio_out;
                have_prev = 1'b1;
            end else begin
                chk("hold_out", audio_out, last_out);
            end
            chk("busy_vs_state", int'(busy), int'(fade_state == 2'd1 || fade_state == 2'd3));
            chk("align_err", int'(align_err), int'(exp_align));
        end
    end

    // One strobe: drive, queue the expected mix, then check the state after
    // the update and through `gap` extra idle cycles with effect_en inverted.
    task automatic strobe(input logic en, input int exp_out, input logic [1:0] exp_st,
                          input int gap, input logic wv);
        @(negedge clk);
        dry_valid = 1'b1;
        wet_valid = wv;
        effect_en = en;
        exp_q.push_back(exp_out);
        @(posedge clk);
        if (!wv) exp_align = ALIGN_ON;
        @(negedge clk);
        dry_valid = 1'b0;
        wet_valid = 1'b0;
        effect_en = ~en;
        chk("state", int'(fade_state), int'(exp_st));
        for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            chk("gap_state", int'(fade_state), int'(exp_st));
        end
    endtask

    typedef struct {
        logic       en;
        int         exp_out;
        logic [1:0] exp_st;
        int         gap;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // fade-in from BYPASS
        vecs.push_back('{1'b1,  1000, 2'd1, 0});
        vecs.push_back('{1'b1,   500, 2'd1, 0});
        vecs.push_back('{1'b1,     0, 2'd1, 0});
        vecs.push_back('{1'b1,  -500, 2'd2, 0});
        vecs.push_back('{1'b1, -1000, 2'd2, 0});
        // fade-out from ACTIVE
        vecs.push_back('{1'b0, -1000, 2'd3, 0});
        vecs.push_back('{1'b0,  -500, 2'd3, 0});
        vecs.push_back('{1'b0,     0, 2'd3, 0});
        vecs.push_back('{1'b0,   500, 2'd0, 0});
        vecs.push_back('{1'b0,  1000, 2'd0, 0});
        // mid-fade reversal
        vecs.push_back('{1'b1,  1000, 2'd1, 0});
        vecs.push_back('{1'b1,   500, 2'd1, 0});
        vecs.push_back('{1'b0,     0, 2'd3, 0});
        vecs.push_back('{1'b0,   500, 2'd0, 0});
        vecs.push_back('{1'b0,  1000, 2'd0, 0});
        // strobe every 4th cycle, effect_en inverted between strobes
        vecs.push_back('{1'b1,  1000, 2'd1, 2});
        vecs.push_back('{1'b1,   500, 2'd1, 2});
        vecs.push_back('{1'b1,     0, 2'd1, 2});
        vecs.push_back('{1'b1,  -500, 2'd2, 2});
        vecs.push_back('{1'b0, -1000, 2'd3, 2});
        vecs.push_back('{1'b0,  -500, 2'd3, 2});
        vecs.push_back('{1'b0,     0, 2'd3, 2});
        vecs.push_back('{1'b0,   500, 2'd0, 2});
        // per-sample toggling oscillates g between 0 and 1
        vecs.push_back('{1'b1,  1000, 2'd1, 0});
        vecs.push_back('{1'b0,   500, 2'd0, 0});
        vecs.push_back('{1'b1,  1000, 2'd1, 0});
        vecs.push_back('{1'b0,   500, 2'd0, 0});

        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) strobe(vecs[i].en, vecs[i].exp_out, vecs[i].exp_st, vecs[i].gap, 1'b1);

        // Reset at g = 2 mid fade-in, effect_en held high: fade restarts from g = 0.
        strobe(1'b1, 1000, 2'd1, 0, 1'b1);
        strobe(1'b1,  500, 2'd1, 0, 1'b1);
        @(negedge clk);
        rst       = 1'b1;
        effect_en = 1'b1;
        exp_align = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        strobe(1'b1, 1000, 2'd1, 0, 1'b1);
        strobe(1'b1,  500, 2'd1, 0, 1'b1);
        strobe(1'b1,    0, 2'd1, 0, 1'b1);
        strobe(1'b0, -500, 2'd3, 0, 1'b1);
        strobe(1'b0,    0, 2'd3, 0, 1'b1);
        strobe(1'b0,  500, 2'd0, 0, 1'b1);
        strobe(1'b0, 1000, 2'd0, 0, 1'b1);

        // Misaligned wet strobe: flag is sticky through aligned samples, mix unaffected.
        strobe(1'b0, 1000, 2'd0, 0, 1'b0);
        strobe(1'b1, 1000, 2'd1, 1, 1'b1);
        strobe(1'b1,  500, 2'd1, 1, 1'b1);
        @(negedge clk);
        rst       = 1'b1;
        exp_align = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
